apb_console_fifo: RTL and testbench
===================================

APB_CONSOLE_FIFO -- requirements
Module: apb_console_fifo

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h1000_0000, meaning the register block base; registers are at BASE+0x0, +0x4 and +0x8.
REQ-002 SHALL have parameter DEPTH, default 16, meaning TX FIFO entries; the value is a power of 2 in the range 2..128.
REQ-003 SHALL have parameter BLOCKING, default 0, meaning full-FIFO write policy: 1 = stall the write, 0 = drop the write and flag an error.
REQ-004 SHALL have parameter PRINT_EN, default 1, meaning that each drained character is also sent to the simulator console via $write("%c").
REQ-005 SHALL have ports, one per line:
  clk_i  in  1  clock.
  rst_ni  in  1  reset, asynchronous, active-low.
  psel_i  in  1  APB select.
  penable_i  in  1  APB enable.
  pwrite_i  in  1  APB write.
  paddr_i  in  32  APB address.
  pwdata_i  in  32  APB write data.
  prdata_o  out  32  APB read data.
  pready_o  out  1  APB ready.
  pslverr_o  out  1  APB error.
  char_valid_o  out  1  drain character valid.
  char_data_o  out  8  drain character.
  char_ready_i  in  1  sink accepts the character.

Function
REQ-006 An access SHALL be psel_i & penable_i; it completes in the cycle where pready_o=1.
REQ-007 The DATA register (+0x0) SHALL behave as follows:
  - a write pushes pwdata_i[7:0] into the FIFO;
  - a read returns 0.
REQ-008 The STATUS register (+0x4) SHALL be read-only and return:
  - [0] empty;
  - [1] full;
  - [2] overflow (sticky);
  - [15:8] count (0..DEPTH);
  - all other bits 0.
  Writes to STATUS are ignored.
REQ-009 The CTRL register (+0x8) SHALL have these bits:
  - [0] drain_en, read/write;
  - [1] flush, write-1, self-clearing, reads 0;
  - [2] ovf_clr, write-1, reads 0.
REQ-010 An access to any other address SHALL complete with pready_o=1 and pslverr_o=1; prdata_o=0 and no state changes.
REQ-011 All accesses SHALL be zero-wait-state (pready_o=1 in the access cycle), except the case in REQ-013.
REQ-012 BLOCKING=0: a DATA write while full (count==DEPTH at that cycle) SHALL complete with pslverr_o=1, drop the data, and set overflow.
REQ-013 BLOCKING=1: a DATA write while full SHALL hold pready_o=0 until count<DEPTH, then complete with pslverr_o=0 and push the data; overflow is never set in this mode.
REQ-014 Full SHALL be evaluated on the registered count; a same-cycle pop does not free space for that cycle's push.
REQ-015 Push and pop in the same cycle (FIFO not full) SHALL leave count unchanged, and FIFO order is preserved.
REQ-016 char_valid_o SHALL be !empty & drain_en.
  - char_data_o is the FIFO head.
  - Both are held stable while char_valid_o=1 and char_ready_i=0.
REQ-017 A pop SHALL occur on char_valid_o & char_ready_i, at most one pop per cycle.
REQ-018 When PRINT_EN=1, the block SHALL execute $write of the popped character in the pop cycle; this has no effect in synthesis.
REQ-019 A push to an empty FIFO SHALL drive char_valid_o=1 from the next cycle (latency 1); there is no bypass.
REQ-020 Clearing drain_en SHALL block pops from the next cycle; pushes continue.
REQ-021 Flush SHALL set count=0 and the pointers to 0 in the write's completion cycle.
  - A pop in that same cycle is discarded.
  - char_valid_o=0 the next cycle.
  - Overflow is unaffected.
REQ-022 A stalled BLOCKING write SHALL complete in the cycle after a flush.
REQ-023 When ovf_clr=1 coincides with a new overflow event, overflow SHALL remain set (set wins).
REQ-024 Pointers SHALL be log2(DEPTH) bits and wrap modulo DEPTH; count is log2(DEPTH)+1 bits.
REQ-025 prdata_o SHALL be combinational from the register state during a read access, and 0 otherwise.

Reset
REQ-026 When rst_ni=0, the block SHALL asynchronously set:
  - FIFO pointers and count to 0;
  - overflow=0;
  - drain_en=1;
  - char_valid_o=0;
  - pslverr_o=0;
  - prdata_o=0.
REQ-027 pready_o SHALL be 1 in reset.
REQ-028 Reset mid-transfer SHALL discard FIFO contents and any stalled write.
REQ-029 Release of rst_ni SHALL take effect at the next clk_i edge, with no spurious pop or push.

Verification
REQ-030 The bench SHALL cover:
  - Basic drain: write 'H','i' to DATA with char_ready_i=1 -> char_data_o sequence 0x48, 0x69; the first valid appears 1 cycle after the push; console prints "Hi".
  - Drop on full (DEPTH=4, BLOCKING=0, drain_en=0): 5 DATA writes -> 5th has pslverr_o=1; STATUS reads 0x0000_0406. Write CTRL=0x4 -> STATUS reads 0x0000_0402.
  - Stall on full (DEPTH=4, BLOCKING=1, FIFO full, char_ready_i=0): write -> pready_o=0. Raise char_ready_i for 1 cycle -> pready_o=1 the next cycle; count stays 4.
  - Backpressure and wrap: 20 chars with random char_ready_i through DEPTH=4 -> output order intact, char_data_o stable while stalled, pointers wrap with no loss.
  - Flush: 3 chars queued, drain_en=0, write CTRL=0x2 -> STATUS reads 0x0000_0001 and no character is emitted after re-enabling drain.
  - Error and reset: read of BASE+0xC -> pslverr_o=1, prdata_o=0. rst_ni low with 2 chars queued -> char_valid_o=0 immediately and STATUS reads 0x0000_0001 after release.

Source files
------------

// File: rtl/apb_console_fifo.sv
// apb_console_fifo: APB-mapped byte FIFO drained to a character sink and,
// in simulation, echoed to the console as each character leaves the FIFO.
module apb_console_fifo #(
    parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
    parameter int unsigned DEPTH     = 16,
    parameter bit          BLOCKING  = 1'b0,
    parameter bit          PRINT_EN  = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        psel_i,
    input  logic        penable_i,
    input  logic        pwrite_i,
    input  logic [31:0] paddr_i,
    input  logic [31:0] pwdata_i,
    output logic [31:0] prdata_o,
    output logic        pready_o,
    output logic        pslverr_o,
    output logic        char_valid_o,
    output logic [7:0]  char_data_o,
    input  logic        char_ready_i
);

    localparam int unsigned AW       = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW:0]   count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          drain_en_q, drain_en_d;

    logic access, sel_data, sel_stat, sel_ctrl;
    logic data_wr, ctrl_wr, full, empty;
    logic push, pop, drop, stall, flush;
    logic unused_pwdata;

    // Gating with rst_ni keeps the bus outputs idle while reset is held.
    assign access   = psel_i & penable_i & rst_ni;
    assign sel_data = (paddr_i == BASE_ADDR);
    assign sel_stat = (paddr_i == BASE_ADDR + 32'h4);
    assign sel_ctrl = (paddr_i == BASE_ADDR + 32'h8);

    assign data_wr = access & pwrite_i & sel_data;
    assign ctrl_wr = access & pwrite_i & sel_ctrl;
    assign full    = (count_q == FULL_CNT);
    assign empty   = (count_q == '0);

    // Full is judged on the registered count only, so a same-cycle pop never frees room.
    assign stall = BLOCKING & data_wr & full;
    assign drop  = ~BLOCKING & data_wr & full;
    assign push  = data_wr & ~full;
    assign flush = ctrl_wr & pwdata_i[1];

    assign char_valid_o = ~empty & drain_en_q;
    assign char_data_o  = mem_q[rptr_q];
    assign pop          = char_valid_o & char_ready_i;

    assign pready_o  = ~stall;
    assign pslverr_o = (access & ~(sel_data | sel_stat | sel_ctrl)) | drop;

    assign unused_pwdata = ^pwdata_i[31:8];

    // Read mux: only STATUS and CTRL return data, everything else reads zero.
    always_comb begin
        prdata_o = '0;
        if (access & ~pwrite_i) begin
            if (sel_stat) begin
                prdata_o = {16'h0, 8'(count_q), 5'h0, ovf_q, full, empty};
            end else if (sel_ctrl) begin
                prdata_o = {31'h0, drain_en_q};
            end
        end
    end

    // Next-state for pointers, count and control bits; flush overrides any pop.
    always_comb begin
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        count_d    = count_q;
        drain_en_d = ctrl_wr ? pwdata_i[0] : drain_en_q;
        ovf_d      = (ovf_q & ~(ctrl_wr & pwdata_i[2])) | drop;
        if (flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (push) wptr_d = wptr_q + AW'(1);
            if (pop)  rptr_d = rptr_q + AW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + (AW+1)'(1);
                2'b01:   count_d = count_q - (AW+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            drain_en_q <= 1'b1;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            drain_en_q <= drain_en_d;
        end
    end

    // FIFO storage; contents need no reset since count gates visibility.
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wptr_q] <= pwdata_i[7:0];
    end

`ifndef SYNTHESIS
    // Echo each character that actually leaves the FIFO to the console.
    always_ff @(posedge clk_i) begin
        if (PRINT_EN && pop && !flush) $write("%c", char_data_o);
    end
`endif

endmodule

// File: tb/tb_apb_console_fifo.sv
// tb_apb_console_fifo: randomized self-checking bench; instance 0 drops on
// full, instance 1 stalls on full, both DEPTH=4, checked against a queue model.
module tb_apb_console_fifo;

    localparam logic [31:0] BASE  = 32'h1000_0000;
    localparam int          DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        psel [2];
    logic        penable [2];
    logic        pwrite [2];
    logic [31:0] paddr [2];
    logic [31:0] pwdata [2];
    logic [31:0] prdata [2];
    logic        pready [2];
    logic        pslverr [2];
    logic        cvalid [2];
    logic [7:0]  cdata [2];
    logic        cready [2];

    apb_console_fifo #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .BLOCKING(1'b0), .PRINT_EN(1'b1)) u_dut_drop (
        .clk_i(clk), .rst_ni(rst_n), .psel_i(psel[0]), .penable_i(penable[0]),
        .pwrite_i(pwrite[0]), .paddr_i(paddr[0]), .pwdata_i(pwdata[0]), .prdata_o(prdata[0]),
        .pready_o(pready[0]), .pslverr_o(pslverr[0]), .char_valid_o(cvalid[0]),
        .char_data_o(cdata[0]), .char_ready_i(cready[0])
    );

    apb_console_fifo #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .BLOCKING(1'b1), .PRINT_EN(1'b0)) u_dut_stall (
        .clk_i(clk), .rst_ni(rst_n), .psel_i(psel[1]), .penable_i(penable[1]),
        .pwrite_i(pwrite[1]), .paddr_i(paddr[1]), .pwdata_i(pwdata[1]), .prdata_o(prdata[1]),
        .pready_o(pready[1]), .pslverr_o(pslverr[1]), .char_valid_o(cvalid[1]),
        .char_data_o(cdata[1]), .char_ready_i(cready[1])
    );

    // Reference model: an unbounded list of pushed bytes per instance.
    logic [7:0]  mbuf [2][256];
    int unsigned mtail [2]  = '{0, 0};
    int unsigned mhead [2]  = '{0, 0};
    int unsigned mflush [2] = '{0, 0};
    bit          mdrain [2] = '{1'b1, 1'b1};
    bit          movf [2]   = '{1'b0, 1'b0};

    int unsigned checks   = 0;
    int unsigned failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic int unsigned head_of(input int i);
        return (mhead[i] > mflush[i]) ? mhead[i] : mflush[i];
    endfunction

    function automatic int unsigned msize(input int i);
        return mtail[i] - head_of(i);
    endfunction

    function automatic logic [31:0] mstatus(input int i);
        int unsigned sz;
        sz = msize(i);
        return {16'h0, 8'(sz), 5'h0, movf[i], (sz == DEPTH), (sz == 0)};
    endfunction

    // One APB transfer with per-cycle ready check and model update after completion.
    task automatic apb(input int i, input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                       output logic [31:0] rdata, output logic err, output int waits);
        logic [31:0] off;
        logic [31:0] exp_rd;
        bit          full, known, exp_rdy, exp_err;
        off   = addr - BASE;
        known = (off == 0) || (off == 4) || (off == 8);
        @(negedge clk);
        psel[i] = 1'b1; penable[i] = 1'b0; pwrite[i] = wr; paddr[i] = addr; pwdata[i] = wdata;
        @(negedge clk);
        penable[i] = 1'b1;
        waits = 0;
        forever begin
            #1;
            full    = (msize(i) == DEPTH);
            exp_rdy = !(i == 1 && wr && off == 0 && full);
            check($sformatf("pready%0d", i), pready[i], exp_rdy);
            if (pready[i] === 1'b1) break;
            waits++;
            if (waits >= 64) begin
                check($sformatf("stall_bound%0d", i), pready[i], 1);
                break;
            end
            @(negedge clk);
        end
        exp_err = !known || (wr && off == 0 && full && i == 0);
        exp_rd  = '0;
        if (!wr && off == 4) exp_rd = mstatus(i);
        else if (!wr && off == 8) exp_rd = {31'h0, mdrain[i]};
        check($sformatf("pslverr%0d", i), pslverr[i], exp_err);
        check($sformatf("prdata%0d", i), prdata[i], exp_rd);
        rdata = prdata[i];
        err   = pslverr[i];
        @(posedge clk);
        #1;
        if (wr && off == 0) begin
            if (!full) begin
                mbuf[i][mtail[i] % 256] = wdata[7:0];
                mtail[i]++;
            end else if (i == 0) begin
                movf[i] = 1'b1;
            end
        end
        if (wr && off == 8) begin
            mdrain[i] = wdata[0];
            if (wdata[2]) movf[i] = 1'b0;
            if (wdata[1]) mflush[i] = mtail[i];
        end
        @(negedge clk);
        psel[i] = 1'b0; penable[i] = 1'b0;
    endtask

    // Sink-side checker: valid, head data, stability under backpressure, pop tracking.
    task automatic monitor(input int i);
        logic       stall_prev = 1'b0;
        logic [7:0] data_prev  = '0;
        bit         exp_v;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                stall_prev = 1'b0;
            end else begin
                exp_v = (msize(i) > 0) && mdrain[i];
                check($sformatf("char_valid%0d", i), cvalid[i], exp_v);
                if (exp_v) begin
                    check($sformatf("char_data%0d", i), cdata[i], mbuf[i][head_of(i) % 256]);
                    if (stall_prev) check($sformatf("char_stable%0d", i), cdata[i], data_prev);
                end
                stall_prev = exp_v && !cready[i];
                data_prev  = cdata[i];
                if (exp_v && cready[i]) mhead[i] = head_of(i) + 1;
            end
        end
    endtask

    initial monitor(0);
    initial monitor(1);

    task automatic wait_drain(input int i);
        cready[i] = 1'b1;
        for (int k = 0; k < 100; k++) begin
            if (msize(i) == 0) break;
            @(negedge clk);
        end
        @(negedge clk);
        #3;
        check($sformatf("drained%0d", i), cvalid[i], 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    logic [31:0] rd;
    logic        err;
    int          waits;
    bit          done;

    initial begin
        rst_n = 1'b0;
        done  = 1'b0;
        for (int i = 0; i < 2; i++) begin
            psel[i] = 1'b1; penable[i] = 1'b1; pwrite[i] = 1'b0;
            paddr[i] = BASE + 32'h4; pwdata[i] = '0; cready[i] = 1'b0;
        end
        repeat (2) @(negedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("rst_pready%0d", i), pready[i], 1);
            check($sformatf("rst_pslverr%0d", i), pslverr[i], 0);
            check($sformatf("rst_prdata%0d", i), prdata[i], 0);
            check($sformatf("rst_valid%0d", i), cvalid[i], 0);
            psel[i] = 1'b0; penable[i] = 1'b0;
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            apb(i, 1'b0, BASE + 32'h4, 0, rd, err, waits);
            check($sformatf("status_after_reset%0d", i), rd, 32'h1);
            apb(i, 1'b0, BASE + 32'h8, 0, rd, err, waits);
            check($sformatf("ctrl_after_reset%0d", i), rd, 32'h1);
        end

        // Basic drain of "Hi".
        cready[0] = 1'b1;
        apb(0, 1'b1, BASE, 32'h48, rd, err, waits);
        apb(0, 1'b1, BASE, 32'h69, rd, err, waits);
        wait_drain(0);

        // Drop on full with drain disabled.
        cready[0] = 1'b0;
        apb(0, 1'b1, BASE + 32'h8, 32'h0, rd, err, waits);
        for (int k = 0; k < 5; k++) apb(0, 1'b1, BASE, 32'h61 + k, rd, err, waits);
        check("drop_err5", err, 1);
        apb(0, 1'b0, BASE + 32'h4, 0, rd, err, waits);
        check("status_full_ovf", rd, 32'h0000_0406);
        apb(0, 1'b1, BASE + 32'h8, 32'h4, rd, err, waits);
        apb(0, 1'b0, BASE + 32'h4, 0, rd, err, waits);
        check("status_ovf_clr", rd, 32'h0000_0402);
        apb(0, 1'b1, BASE + 32'h4, 32'hFFFF_FFFF, rd, err, waits);
        apb(0, 1'b0, BASE + 32'h4, 0, rd, err, waits);
        check("status_wr_ignored", rd, 32'h0000_0402);

        // Flush with three queued.
        apb(0, 1'b1, BASE + 32'h8, 32'h2, rd, err, waits);
        for (int k = 0; k < 3; k++) apb(0, 1'b1, BASE, 32'h70 + k, rd, err, waits);
        apb(0, 1'b0, BASE + 32'h4, 0, rd, err, waits);
        check("status_three", rd, 32'h0000_0300);
        apb(0, 1'b1, BASE + 32'h8, 32'h2, rd, err, waits);
        apb(0, 1'b0, BASE + 32'h4, 0, rd, err, waits);
        check("status_flushed", rd, 32'h0000_0001);
        cready[0] = 1'b1;
        apb(0, 1'b1, BASE + 32'h8, 32'h1, rd, err, waits);
        repeat (5) @(negedge clk);

        // Unmapped addresses.
        apb(0, 1'b0, BASE + 32'hC, 0, rd, err, waits);
        check("bad_rd_err", err, 1);
        check("bad_rd_data", rd, 0);
        apb(0, 1'b1, BASE + 32'h10, 32'h7A, rd, err, waits);
        apb(0, 1'b0, BASE + 32'h4, 0, rd, err, waits);
        check("status_after_bad", rd, 32'h0000_0001);

        // Stall on full, released by a one-cycle sink pulse.
        cready[1] = 1'b0;
        for (int k = 0; k < 4; k++) apb(1, 1'b1, BASE, 32'h41 + k, rd, err, waits);
        fork
            apb(1, 1'b1, BASE, 32'h45, rd, err, waits);
            begin
                repeat (3) @(negedge clk);
                cready[1] = 1'b1;
                @(negedge clk);
                cready[1] = 1'b0;
            end
        join
        check("stall_waits", waits, 2);
        check("stall_err", err, 0);
        apb(1, 1'b0, BASE + 32'h4, 0, rd, err, waits);
        check("status_stall_full", rd, 32'h0000_0402);
        wait_drain(1);

        // Backpressure and pointer wrap through the stalling instance.
        fork
            begin
                for (int k = 0; k < 20; k++) apb(1, 1'b1, BASE, 32'($urandom_range(97, 122)), rd, err, waits);
                done = 1'b1;
            end
            while (!done) begin
                @(negedge clk);
                cready[1] = 1'($urandom_range(0, 1));
            end
        join
        done = 1'b0;
        wait_drain(1);
        apb(1, 1'b0, BASE + 32'h4, 0, rd, err, waits);
        check("status_wrap_empty", rd, 32'h0000_0001);

        // Random operation mix on the dropping instance.
        fork
            begin
                for (int k = 0; k < 40; k++) begin
                    int unsigned r;
                    r = $urandom_range(0, 9);
                    if (r <= 5) apb(0, 1'b1, BASE, 32'($urandom_range(97, 122)), rd, err, waits);
                    else if (r <= 7) apb(0, 1'b0, BASE + 32'h4, 0, rd, err, waits);
                    else if (r == 8) apb(0, 1'b1, BASE + 32'h8,
                                         {29'h0, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                                          ($urandom_range(0, 3) != 0)}, rd, err, waits);
                    else apb(0, 1'b0, ($urandom_range(0, 1) == 0) ? BASE + 32'h8 : BASE + 32'h20, 0, rd, err, waits);
                end
                done = 1'b1;
            end
            while (!done) begin
                @(negedge clk);
                cready[0] = 1'($urandom_range(0, 1));
            end
        join
        done = 1'b0;
        apb(0, 1'b1, BASE + 32'h8, 32'h5, rd, err, waits);
        wait_drain(0);

        // Reset with two characters queued.
        cready[0] = 1'b0;
        apb(0, 1'b1, BASE + 32'h8, 32'h0, rd, err, waits);
        apb(0, 1'b1, BASE, 32'h51, rd, err, waits);
        apb(0, 1'b1, BASE, 32'h52, rd, err, waits);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_mid_valid", cvalid[0], 0);
        check("rst_mid_pready", pready[0], 1);
        for (int i = 0; i < 2; i++) begin
            mflush[i] = mtail[i];
            mdrain[i] = 1'b1;
            movf[i]   = 1'b0;
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cready[0] = 1'b1;
        apb(0, 1'b0, BASE + 32'h4, 0, rd, err, waits);
        check("status_after_midrst", rd, 32'h0000_0001);
        repeat (4) @(negedge clk);

        $display("");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
